// File: rtl/alu_result_checker_if.sv
// rtl/alu_result_checker_if.sv - sample bundle carrying DUT and golden ALU results to the checker
interface alu_result_checker_if #(
    parameter int WIDTH  = 8,
    parameter int OPCODE = 3
);
    logic              sample;
    logic [OPCODE-1:0] op_code;
    logic [WIDTH-1:0]  dut_data;
    logic [3:0]        dut_flags;
    logic [WIDTH-1:0]  gold_data;
    logic [3:0]        gold_flags;

    modport master (
        output sample,
        output op_code,
        output dut_data,
        output dut_flags,
        output gold_data,
        output gold_flags
    );

    modport slave (
        input sample,
        input op_code,
        input dut_data,
        input dut_flags,
        input gold_data,
        input gold_flags
    );
endinterface

// File: rtl/alu_result_checker.sv
// rtl/alu_result_checker.sv - compares DUT vs golden ALU bundles over a run, counts and captures first fail
module alu_result_checker #(
    parameter int WIDTH     = 8,
    parameter int OPCODE    = 3,
    parameter int NUM_TESTS = 20,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    alu_result_checker_if.slave   smp,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      match_cnt,
    output logic [CNT_W-1:0]      mismatch_cnt,
    output logic                  fail_valid,
    output logic [CNT_W-1:0]      fail_idx,
    output logic [OPCODE-1:0]     fail_op,
    output logic [WIDTH+3:0]      fail_dut,
    output logic [WIDTH+3:0]      fail_gold
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TESTS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             clear;
    logic             mismatch;
    logic [WIDTH+3:0] dut_word;
    logic [WIDTH+3:0] gold_word;
    logic [CNT_W-1:0] sample_idx;

    // Full-width compare: flags are checked even for ops that leave them undefined.
    always_comb begin
        dut_word  = {smp.dut_data, smp.dut_flags};
        gold_word = {smp.gold_data, smp.gold_flags};
        mismatch  = (dut_word != gold_word);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        clear     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    clear     = 1'b1;
                end
            end
            ST_RUN: begin
                if (smp.sample) begin
                    accept = 1'b1;
                    if (sample_idx == LAST_IDX) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    clear     = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_idx   <= '0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
        end else if (clear) begin
            sample_idx   <= '0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
        end else if (accept) begin
            if (sample_idx != CNT_MAX) begin
                sample_idx <= sample_idx + 1'b1;
            end
            if (mismatch) begin
                if (mismatch_cnt != CNT_MAX) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                end
            end else begin
                if (match_cnt != CNT_MAX) begin
                    match_cnt <= match_cnt + 1'b1;
                end
            end
        end
    end

    // Only the first mismatch of a run is captured; later ones leave it intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_valid <= 1'b0;
            fail_idx   <= '0;
            fail_op    <= '0;
            fail_dut   <= '0;
            fail_gold  <= '0;
        end else if (clear) begin
            fail_valid <= 1'b0;
            fail_idx   <= '0;
            fail_op    <= '0;
            fail_dut   <= '0;
            fail_gold  <= '0;
        end else if (accept && mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_idx   <= sample_idx;
            fail_op    <= smp.op_code;
            fail_dut   <= dut_word;
            fail_gold  <= gold_word;
        end
    end

    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
        pass = done && (mismatch_cnt == '0);
    end

endmodule
